// File: rtl/jtag_tap_sequencer_if.sv
// jtag_tap_sequencer_if: host command/response channel and TAP status for the JTAG sequencer
interface jtag_tap_sequencer_if #(
  parameter int MAX_LEN = 32
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [5:0]         cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;
  logic               tap_known;
  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, tap_known
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, tap_known
  );
endinterface

// File: rtl/jtag_tap_sequencer.sv
// jtag_tap_sequencer: command-driven JTAG master bit-banging a target TAP from the system clock
module jtag_tap_sequencer #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 32
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  jtag_tap_sequencer_if.slave  bus,
  output logic                 TGT_TCK,
  output logic                 TGT_TMS,
  output logic                 TGT_TDI,
  output logic                 TGT_TRSTB,
  input  logic                 TGT_TDO
);
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SHIFT, S_POST, S_DONE} state_t;
  localparam logic [1:0] OP_RST = 2'd0, OP_IR = 2'd1, OP_DR = 2'd2, OP_IDLE = 2'd3;
  localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  state_t             r_state, w_nstate;
  logic [6:0]         r_cnt, w_ncnt, r_len, w_len, w_cmd_len, w_pre_len, w_plen;
  logic [1:0]         r_op, w_op;
  logic [MAX_LEN-1:0] r_data, w_data, r_cap;
  logic [DW-1:0]      r_div;
  logic               r_half, r_tck, r_tms, r_tdi, r_trstb, r_known, r_err;
  logic               w_acc, w_rej, w_active, w_tick, w_rise, w_end, w_last, w_start;
  logic               w_tms, w_tdi, w_trstb;
  assign bus.cmd_ready = (r_state == S_IDLE) || (r_state == S_DONE);
  assign bus.rsp_valid = r_state == S_DONE;
  assign bus.rsp_data  = r_cap;
  assign bus.rsp_err   = r_err;
  assign bus.tap_known = r_known;
  assign TGT_TCK   = r_tck;
  assign TGT_TMS   = r_tms;
  assign TGT_TDI   = r_tdi;
  assign TGT_TRSTB = r_trstb;
  assign w_acc = bus.cmd_valid && bus.cmd_ready;
  assign w_rej = w_acc && (bus.cmd_op[0] ^ bus.cmd_op[1]) && !r_known;
  // idle-clock counts are not scan lengths, so only zero is remapped for them
  assign w_cmd_len = (bus.cmd_op == OP_IDLE) ? (bus.cmd_len == 6'd0 ? 7'd64 : {1'b0, bus.cmd_len})
                   : (bus.cmd_len == 6'd0) ? 7'd1
                   : ({1'b0, bus.cmd_len} > 7'(MAX_LEN)) ? 7'(MAX_LEN) : {1'b0, bus.cmd_len};
  assign w_op   = w_acc ? bus.cmd_op : r_op;
  assign w_len  = w_acc ? w_cmd_len : r_len;
  assign w_data = w_acc ? bus.cmd_data : r_data;
  assign w_active = (r_state == S_PRE) || (r_state == S_SHIFT) || (r_state == S_POST);
  assign w_tick   = w_active && (r_div == DW'(CLK_DIV - 1));
  assign w_rise   = w_tick && !r_half;
  assign w_end    = w_tick && r_half;
  assign w_pre_len = (w_op == OP_RST) ? 7'd6 : (w_op == OP_IR) ? 7'd4 : (w_op == OP_DR) ? 7'd3 : w_len;
  assign w_plen    = (r_state == S_PRE) ? w_pre_len : (r_state == S_SHIFT) ? r_len : 7'd2;
  assign w_last    = r_cnt == w_plen - 7'd1;
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    if (w_acc) begin
      w_nstate = w_rej ? S_DONE : S_PRE;
      w_ncnt   = '0;
    end else if (r_state == S_DONE) begin
      w_nstate = S_IDLE;
    end else if (w_end) begin
      w_ncnt = w_last ? 7'd0 : r_cnt + 7'd1;
      if (w_last)
        w_nstate = (r_state == S_PRE) ? ((r_op[0] ^ r_op[1]) ? S_SHIFT : S_DONE)
                 : (r_state == S_SHIFT) ? S_POST : S_DONE;
    end
    w_start = (w_acc && !w_rej) || (w_end && w_nstate != S_DONE);
    // pin values for the bit that starts at this edge
    w_tms = (w_nstate == S_PRE) ? ((w_op == OP_RST) ? (w_ncnt < 7'd5) : (w_op == OP_IR) ? (w_ncnt < 7'd2)
                                 : (w_op == OP_DR) ? (w_ncnt < 7'd1) : 1'b0)
          : (w_nstate == S_SHIFT) ? (w_ncnt == w_len - 7'd1) : (w_ncnt == 7'd0);
    w_tdi   = (w_nstate == S_SHIFT) && w_data[w_ncnt[IW-1:0]];
    w_trstb = !((w_nstate == S_PRE) && (w_op == OP_RST) && (w_ncnt < 7'd5));
  end
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
    end
  end
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_div   <= '0;
      r_half  <= 1'b0;
      r_op    <= '0;
      r_len   <= '0;
      r_data  <= '0;
      r_cap   <= '0;
      r_err   <= 1'b0;
      r_known <= 1'b0;
      r_tck   <= 1'b0;
      r_tms   <= 1'b1;
      r_tdi   <= 1'b0;
      r_trstb <= 1'b1;
    end else begin
      r_div <= (!w_active || w_tick) ? '0 : r_div + 1'b1;
      if (w_rise) begin
        r_half <= 1'b1;
        r_tck  <= 1'b1;
        if (r_state == S_SHIFT) r_cap[r_cnt[IW-1:0]] <= TGT_TDO;
      end
      if (w_end) begin
        r_half <= 1'b0;
        r_tck  <= 1'b0;
      end
      if (w_acc) begin
        r_op   <= bus.cmd_op;
        r_len  <= w_cmd_len;
        r_data <= bus.cmd_data;
        r_cap  <= '0;
        r_err  <= w_rej;
      end
      if (w_start) begin
        r_tms   <= w_tms;
        r_tdi   <= w_tdi;
        r_trstb <= w_trstb;
      end
      if (w_end && w_nstate == S_DONE && r_op == OP_RST) r_known <= 1'b1;
    end
  end
endmodule

// File: tb/tb_jtag_tap_sequencer.sv
// tb_jtag_tap_sequencer: random and directed commands against a behavioural 16-state TAP target
module tb_jtag_tap_sequencer;
  localparam int CD = 2;
  typedef enum int {TLR, RTI, SDS, CDR, SHDR, E1DR, PDR, E2DR, UDR, SIS, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_t;
  logic clk = 1'b0, resetn = 1'b0;
  logic tgt_tck, tgt_tms, tgt_tdi, tgt_trstb, tgt_tdo;
  logic m_tdo = 1'b0, loop = 1'b0;
  logic [31:0] tdo_word = '0, m_rx = '0;
  tap_t m_st = TLR;
  int m_k = 0;
  bit m_prev = 1'b0, exp_known = 1'b0;
  int n_chk = 0, n_fail = 0;
  jtag_tap_sequencer_if #(.MAX_LEN(32)) bus ();
  jtag_tap_sequencer #(.CLK_DIV(CD), .MAX_LEN(32)) dut (
    .CLK(clk), .RESETN(resetn), .bus(bus),
    .TGT_TCK(tgt_tck), .TGT_TMS(tgt_tms), .TGT_TDI(tgt_tdi), .TGT_TRSTB(tgt_trstb), .TGT_TDO(tgt_tdo)
  );
  assign tgt_tdo = loop ? tgt_tdi : m_tdo;
  always #5 clk = ~clk;
  function automatic tap_t tap_next(tap_t s, logic tms);
    case (s)
      TLR:  return tms ? TLR  : RTI;
      RTI:  return tms ? SDS  : RTI;
      SDS:  return tms ? SIS  : CDR;
      CDR:  return tms ? E1DR : SHDR;
      SHDR: return tms ? E1DR : SHDR;
      E1DR: return tms ? UDR  : PDR;
      PDR:  return tms ? E2DR : PDR;
      E2DR: return tms ? UDR  : SHDR;
      UDR:  return tms ? SDS  : RTI;
      SIS:  return tms ? TLR  : CIR;
      CIR:  return tms ? E1IR : SHIR;
      SHIR: return tms ? E1IR : SHIR;
      E1IR: return tms ? UIR  : PIR;
      PIR:  return tms ? E2IR : PIR;
      E2IR: return tms ? UIR  : SHIR;
      default: return tms ? SDS : RTI;
    endcase
  endfunction
  always @(negedge clk) begin
    if (!tgt_trstb) m_st = TLR;
    if (tgt_tck && !m_prev) begin
      if (m_st == SHDR || m_st == SHIR) begin
        if (m_k < 32) m_rx[m_k] = tgt_tdi;
        m_k++;
      end
      if (m_st == CDR || m_st == CIR) begin
        m_k = 0;
        m_rx = '0;
      end
      m_st = tgt_trstb ? tap_next(m_st, tgt_tms) : TLR;
    end
    if (!tgt_tck && m_prev) m_tdo = ((m_st == SHDR || m_st == SHIR) && m_k < 32) ? tdo_word[m_k] : 1'b0;
    m_prev = tgt_tck;
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic int eff_len(input logic [1:0] op, input logic [5:0] len);
    if (op == 2'd3) return len == 0 ? 64 : int'(len);
    if (len == 0) return 1;
    return len > 32 ? 32 : int'(len);
  endfunction
  function automatic logic [31:0] msk(input int l);
    logic [63:0] m;
    m = (64'd1 << l) - 64'd1;
    return m[31:0];
  endfunction
  function automatic void build(input logic [1:0] op, input int l, input logic [31:0] d,
                                output int n, output logic [127:0] tms, output logic [127:0] tdi,
                                output logic [127:0] trs);
    logic [3:0] pre;
    n = 0; tms = '0; tdi = '0; trs = '1;
    if (op == 2'd0) begin
      for (int i = 0; i < 6; i++) begin tms[i] = i < 5; trs[i] = i >= 5; end
      n = 6;
    end else if (op == 2'd3) begin
      n = l;
    end else begin
      pre = (op == 2'd1) ? 4'b0011 : 4'b0001;
      for (int i = 0; i < ((op == 2'd1) ? 4 : 3); i++) begin tms[n] = pre[i]; n++; end
      for (int k = 0; k < l; k++) begin tms[n] = (k == l - 1); tdi[n] = d[k]; n++; end
      tms[n] = 1'b1; n++;
      tms[n] = 1'b0; n++;
    end
  endfunction
  task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] d,
                         input logic [31:0] tw, input bit lp);
    int l, n, k, nr, first, g;
    logic [127:0] et, ed, er, ot, od, orr;
    logic [31:0] ed_rsp;
    bit rej, prev;
    l = eff_len(op, len);
    build(op, l, d, n, et, ed, er);
    rej = (op == 2'd1 || op == 2'd2) && !exp_known;
    if (rej) n = 0;
    ed_rsp = rej || !(op == 2'd1 || op == 2'd2) ? 32'd0 : (lp ? d : tw) & msk(l);
    @(negedge clk);
    tdo_word = tw; loop = lp;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_len = len; bus.cmd_data = d;
    for (g = 0; g < 50 && !bus.cmd_ready; g++) @(negedge clk);
    chk("ready_idle", bus.cmd_ready, 1);
    @(posedge clk);
    ot = '0; od = '0; orr = '1; nr = 0; first = 0; prev = 1'b0;
    for (k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.cmd_valid = 1'b0;
        chk("ready_after_acc", bus.cmd_ready, rej);
      end
      if (tgt_tck && !prev) begin
        if (nr < 128) begin ot[nr] = tgt_tms; od[nr] = tgt_tdi; orr[nr] = tgt_trstb; end
        if (nr == 0) first = k;
        nr++;
      end
      prev = tgt_tck;
      if (bus.rsp_valid) break;
    end
    chk("rsp_latency", k, 2 * CD * n + 1);
    chk("tck_count", nr, n);
    if (n > 0) begin
      chk("first_rise", first, CD + 1);
      chk("tms_seq", ot, et);
      chk("tdi_seq", od, ed);
      chk("trstb_seq", orr, er);
    end
    chk("rsp_err", bus.rsp_err, rej);
    chk("rsp_data", bus.rsp_data, ed_rsp);
    if (op == 2'd0) exp_known = 1'b1;
    chk("tap_known", bus.tap_known, exp_known);
    if ((op == 2'd1 || op == 2'd2) && !rej) chk("target_rx", m_rx & msk(l), d & msk(l));
    if (exp_known && !rej) chk("target_in_rti", m_st, RTI);
    @(negedge clk);
    chk("rsp_pulse", bus.rsp_valid, 0);
    chk("rsp_hold", {bus.rsp_err, bus.rsp_data}, {rej, ed_rsp});
  endtask
  task automatic chk_reset_pins(input string tag);
    chk({tag, "_pins"}, {tgt_tck, tgt_tms, tgt_tdi, tgt_trstb}, 4'b0101);
    chk({tag, "_rsp"}, {bus.rsp_valid, bus.rsp_err, bus.tap_known, bus.rsp_data}, '0);
  endtask
  initial begin
    int nr, k;
    bit prev, seen;
    logic [1:0] op;
    logic [5:0] len;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_len = '0; bus.cmd_data = '0;
    repeat (3) @(negedge clk);
    chk_reset_pins("reset");
    resetn = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", bus.cmd_ready, 1);
    run_cmd(2'd2, 6'd8, 32'hA5, 32'h0, 1'b0);
    run_cmd(2'd3, 6'd3, 32'h0, 32'h0, 1'b0);
    run_cmd(2'd0, 6'd0, 32'h0, 32'h0, 1'b0);
    run_cmd(2'd1, 6'd8, 32'h55, 32'h0, 1'b1);
    run_cmd(2'd2, 6'd32, 32'hDEADBEEF, 32'h12345678, 1'b0);
    run_cmd(2'd3, 6'd0, 32'hFFFFFFFF, 32'h0, 1'b0);
    run_cmd(2'd2, 6'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_cmd(2'd1, 6'd40, 32'hC3A5_0F1E, 32'h8765_4321, 1'b0);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2; bus.cmd_len = 6'd20; bus.cmd_data = 32'hABCDE;
    @(posedge clk);
    nr = 0; prev = 1'b0; seen = 1'b0;
    for (k = 0; k < 500 && nr < 11; k++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      seen |= bus.rsp_valid;
      if (tgt_tck && !prev) nr++;
      prev = tgt_tck;
    end
    chk("midreset_reached", nr, 11);
    resetn = 1'b0;
    @(negedge clk);
    exp_known = 1'b0;
    chk_reset_pins("midreset");
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen |= bus.rsp_valid;
    end
    chk("midreset_ready", bus.cmd_ready, 1);
    chk("midreset_no_rsp", seen, 0);
    run_cmd(2'd1, 6'd5, 32'h1F, 32'h0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      len = (op == 2'd3) ? (($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 10)))
                         : 6'($urandom_range(0, 40));
      if (i == 0) op = 2'd0;
      run_cmd(op, len, $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
